// File: rtl/tri_pkg.sv
// Shared types for the triangle bounding-box scanner: default coordinate width,
// scanner state encoding and a 2-D point.
package tri_pkg;

    localparam int TRI_CW = 12;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BBOX = 2'd1,
        SCAN = 2'd2,
        DONE = 2'd3
    } state_t;

    typedef struct packed {
        logic [TRI_CW-1:0] x;
        logic [TRI_CW-1:0] y;
    } point_t;

endpackage

// File: rtl/min_max3.sv
// Combinational unsigned minimum and maximum of three values.
module min_max3 #(
    parameter int W = 12
)(
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic [W-1:0] c,
    output logic [W-1:0] min_v,
    output logic [W-1:0] max_v
);

    logic [W-1:0] ab_lo;
    logic [W-1:0] ab_hi;

    // NOTE: every always_comb output gets a value on every path, so no latch is inferred.
    always_comb begin
        ab_lo = (a < b) ? a : b;
        ab_hi = (a < b) ? b : a;
        min_v = (ab_lo < c) ? ab_lo : c;
        max_v = (ab_hi > c) ? ab_hi : c;
    end

endmodule

// File: rtl/tri_bbox_scanner.sv
// Latches a triangle, computes its bounding box and streams every box point
// (row-major) with the external tester's inside flag, counting inside points.
module tri_bbox_scanner
    import tri_pkg::*;
#(
    parameter int CW   = TRI_CW,
    parameter int CNTW = 2*CW+1
)(
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [CW-1:0]   ax,
    input  logic [CW-1:0]   ay,
    input  logic [CW-1:0]   bx,
    input  logic [CW-1:0]   by,
    input  logic [CW-1:0]   cx,
    input  logic [CW-1:0]   cy,
    output logic            busy,
    output logic [CW-1:0]   probe_x,
    output logic [CW-1:0]   probe_y,
    input  logic            probe_in,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [CW-1:0]   out_x,
    output logic [CW-1:0]   out_y,
    output logic            out_inside,
    output logic [CNTW-1:0] hit_count,
    output logic            done
);

    state_t        state;
    logic [CW-1:0] ax_q, ay_q, bx_q, by_q, cx_q, cy_q;
    logic [CW-1:0] xmin, xmax, ymin, ymax;
    logic [CW-1:0] x, y;
    logic [CW-1:0] x_lo, x_hi, y_lo, y_hi;
    logic          xfer;

    min_max3 #(.W(CW)) u_mm_x (.a(ax_q), .b(bx_q), .c(cx_q), .min_v(x_lo), .max_v(x_hi));
    min_max3 #(.W(CW)) u_mm_y (.a(ay_q), .b(by_q), .c(cy_q), .min_v(y_lo), .max_v(y_hi));

    assign probe_x    = x;
    assign probe_y    = y;
    assign out_x      = x;
    assign out_y      = y;
    // The tester answer is passed straight through; it is only meaningful while offering.
    assign out_inside = out_valid & probe_in;
    assign xfer       = out_valid & out_ready;

    // NOTE: sequential state uses non-blocking assignments so every register
    // updates from the same pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            busy      <= 1'b0;
            out_valid <= 1'b0;
            done      <= 1'b0;
            hit_count <= '0;
            x         <= '0;
            y         <= '0;
            // NOTE: the latched triangle and box are plain flops, not RAM, so
            // they are cleared too and nothing from an aborted scan survives.
            ax_q <= '0; ay_q <= '0; bx_q <= '0; by_q <= '0; cx_q <= '0; cy_q <= '0;
            xmin <= '0; xmax <= '0; ymin <= '0; ymax <= '0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        ax_q      <= ax;
                        ay_q      <= ay;
                        bx_q      <= bx;
                        by_q      <= by;
                        cx_q      <= cx;
                        cy_q      <= cy;
                        hit_count <= '0;
                        busy      <= 1'b1;
                        state     <= BBOX;
                    end
                end
                BBOX: begin
                    xmin      <= x_lo;
                    xmax      <= x_hi;
                    ymin      <= y_lo;
                    ymax      <= y_hi;
                    x         <= x_lo;
                    y         <= y_lo;
                    out_valid <= 1'b1;
                    state     <= SCAN;
                end
                SCAN: begin
                    if (xfer) begin
                        if (probe_in) begin
                            hit_count <= hit_count + CNTW'(1);
                        end
                        // Compare against the box edge rather than relying on
                        // overflow, so a box touching 2^CW-1 never wraps.
                        if (x != xmax) begin
                            x <= x + CW'(1);
                        end else if (y != ymax) begin
                            x <= xmin;
                            y <= y + CW'(1);
                        end else begin
                            out_valid <= 1'b0;
                            done      <= 1'b1;
                            state     <= DONE;
                        end
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
